store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the multi-cycle CPU's data port and the slow backing store (SD-backed data memory). It accepts each CPU store in one cycle, returns `WRITE_OK` to the CPU's store state, and drains entries in order to the backing store over a request/acknowledge channel. Loads read the backing store directly; a hit on a pending entry is forwarded from the buffer.

## Interface
Parameters:
- `DEPTH`, 4: number of buffer entries; power of two, at least 2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `CPU_ADDR`  in  AW  CPU data address, used for both loads and stores.
- `CPU_WDATA`  in  DW  CPU store data.
- `CPU_WE`  in  1  store request; a level held by the CPU's store state.
- `CPU_RDATA`  out  DW  load data, either forwarded from the buffer or passed through from `MEM_RDATA`.
- `WRITE_OK`  out  1  one-cycle store-accepted pulse; drives the CPU's `SD_WRITE_OK`.
- `EMPTY`  out  1  high when the buffer holds no entries and no drain request is outstanding.
- `MEM_RADDR`  out  AW  backing-store read address; equal to `CPU_ADDR`.
- `MEM_RDATA`  in  DW  backing-store read data.
- `MEM_WADDR`  out  AW  address of the head entry.
- `MEM_WDATA`  out  DW  data of the head entry.
- `MEM_WREQ`  out  1  write request to the backing store.
- `MEM_WACK`  in  1  backing store has completed the head write.

## Operation
**Storage**
- Circular FIFO of {addr, data} entries, indexed by `wr_ptr` and `rd_ptr`.
- `count` covers 0..DEPTH and is stored in $clog2(DEPTH)+1 bits.
- Both pointers wrap modulo DEPTH.

**Store acceptance**
- An `armed` flag is set at reset and set again on any cycle where `CPU_WE`=0.
- A store is accepted when, at the clock edge, `CPU_WE`=1, `armed`=1 and `count`<DEPTH.
- On acceptance: push {`CPU_ADDR`, `CPU_WDATA`}, clear `armed`, and register `WRITE_OK`=1 for exactly one cycle.
- A `CPU_WE` held high across several cycles therefore produces exactly one entry.
- When the buffer is full, acceptance is deferred. The test uses `count` at the start of the cycle, so a same-cycle pop does not admit the push. `WRITE_OK` stays low until the store is taken, and the CPU waits in its store state.

**Drain FSM** (states IDLE, BUSY)
- `MEM_WREQ` = (state==BUSY).
- `MEM_WADDR` and `MEM_WDATA` show the `rd_ptr` entry and are stable while `MEM_WREQ` is high.
- IDLE→BUSY: on the edge where `count` becomes non-zero.
- BUSY with `MEM_WACK`=1: pop the head. Go to IDLE if the post-pop count (including any same-edge push) is 0; otherwise stay BUSY with the next head.
- `MEM_WACK` received in IDLE is ignored.

**Simultaneous push and pop**
- `count` is unchanged and both pointers advance.

**Load forwarding** (combinational)
- Compare `CPU_ADDR` (full AW bits) against all valid entries.
- On a match, `CPU_RDATA` = data of the youngest matching entry. Otherwise `CPU_RDATA` = `MEM_RDATA`.
- The head entry remains forwardable until the edge at which it is popped.

**`EMPTY`**
- `EMPTY` = (`count`==0).

## Timing
- Reset values:
  - `WRITE_OK`=0, `MEM_WREQ`=0, `EMPTY`=1.
  - `count`, `wr_ptr`, `rd_ptr` = 0; state = IDLE; `armed`=1.
  - Entry contents are don't-care.
- Store latency: `CPU_WE` sampled high at edge k. `WRITE_OK`=1 in cycle k→k+1. The entry is visible to forwarding, and `MEM_WREQ` is high, from the same cycle when the buffer was empty.
- Drain: one entry retires per `MEM_WACK` cycle. Back-to-back acknowledgements drain one entry per clock.
- Reset while BUSY discards all entries and drops `MEM_WREQ` after the edge. The backing store must abandon any in-flight write.
- `CPU_RDATA`, `MEM_RADDR`, `MEM_WADDR` and `MEM_WDATA` are combinational with respect to registered state and `CPU_ADDR`/`MEM_RDATA`. There is no pipeline latency on loads.

## Structure
- Shared package `mem_sys_pkg` holds:
  - the drain state enum {`SB_IDLE`, `SB_BUSY`};
  - the default depth constant `SB_DEPTH`=4.
- Sub-module `sb_fwd_match`: parameterised youngest-first priority search. Inputs are the entry array, a valid mask, `rd_ptr` and `CPU_ADDR`; outputs are `hit` and the data.
- FIFO control, the `armed` logic and the FSM stay in `store_buffer`.

## Test plan
- **Single store:** `CPU_WE` held 3 cycles with addr 0x100, data 0xDEADBEEF, `MEM_WACK` tied 0 → one entry, `WRITE_OK` high exactly 1 cycle, `MEM_WREQ`=1 with `MEM_WADDR`=0x100, `MEM_WDATA`=0xDEADBEEF, `EMPTY`=0.
- **Forwarding:** store 0x11 then 0x22 to 0x200, both undrained; load 0x200 with `MEM_RDATA`=0x0 → `CPU_RDATA`=0x22. Load 0x204 → `MEM_RDATA` passes through.
- **Full buffer:** 5 stores with `MEM_WACK`=0 → 4 `WRITE_OK` pulses; the fifth store has no pulse. Pulse `MEM_WACK` once → fifth store accepted on the following edge and its `WRITE_OK` follows.
- **In-order drain:** stores A, B, C, then `MEM_WACK`=1 continuously → `MEM_WADDR` sequence A, B, C on consecutive cycles, then `MEM_WREQ`=0 and `EMPTY`=1.
- **Push and pop together:** `count`=2, a store accepted on the same edge as `MEM_WACK` → `count` stays 2, FIFO order preserved, and `wr_ptr` wraps correctly after 4 more stores.
- **Reset mid-drain:** 3 entries pending, `RST` for 1 cycle → `MEM_WREQ`=0, `EMPTY`=1, `WRITE_OK`=0. A load to a previously buffered address returns `MEM_RDATA`.

Source files
------------

// File: rtl/mem_sys_pkg.sv
// Shared memory-subsystem types and defaults.
package mem_sys_pkg;

  // Drain state of the store buffer.
  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

  // Default number of store-buffer entries.
  localparam int unsigned SB_DEPTH = 4;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match across the pending store-buffer entries.
module sb_fwd_match
  import mem_sys_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic [AW-1:0]             entry_addr [DEPTH],
  input  logic [DW-1:0]             entry_data [DEPTH],
  input  logic [DEPTH-1:0]          valid,
  input  logic [$clog2(DEPTH)-1:0]  rd_ptr,
  input  logic [AW-1:0]             addr,
  output logic                      hit,
  output logic [DW-1:0]             data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (valid[idx] && (entry_addr[idx] == addr)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU data port and the slow backing store.
module store_buffer
  import mem_sys_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  input  logic          CPU_WE,
  output logic [DW-1:0] CPU_RDATA,
  output logic          WRITE_OK,
  output logic          EMPTY,
  output logic [AW-1:0] MEM_RADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [AW-1:0] MEM_WADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WREQ,
  input  logic          MEM_WACK
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             armed;
  sb_state_e        state;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    age;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;
  logic             write_ok_q;
  logic             empty_q;

  // Accept one store per CPU_WE level; full check uses the start-of-cycle count.
  always_comb begin
    push       = CPU_WE && armed && (count < CW'(DEPTH));
    pop        = (state == SB_BUSY) && MEM_WACK;
    count_next = count + CW'(push) - CW'(pop);
  end

  // An entry is valid when its distance from the head is below count.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - rd_ptr;
      valid[i] = CW'(age) < count;
    end
  end

  // FIFO pointers, occupancy, store arming and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      armed      <= 1'b1;
      write_ok_q <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      if (!CPU_WE) begin
        armed <= 1'b1;
      end else if (push) begin
        armed <= 1'b0;
      end
      write_ok_q <= push;
      empty_q    <= (count_next == '0);
    end
  end

  // Entry storage; contents need no reset since validity comes from count.
  always_ff @(posedge CLK) begin
    if (push) begin
      entry_addr[wr_ptr] <= CPU_ADDR;
      entry_data[wr_ptr] <= CPU_WDATA;
    end
  end

  // Drain FSM: request while any entry is pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SB_IDLE;
    end else begin
      case (state)
        SB_IDLE: if (count_next != '0) state <= SB_BUSY;
        SB_BUSY: if (pop && (count_next == '0)) state <= SB_IDLE;
        default: state <= SB_IDLE;
      endcase
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .valid      (valid),
    .rd_ptr     (rd_ptr),
    .addr       (CPU_ADDR),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

  // Loads go straight to the backing store unless a pending store matches.
  assign CPU_RDATA = fwd_hit ? fwd_data : MEM_RDATA;
  assign MEM_RADDR = CPU_ADDR;
  assign MEM_WADDR = entry_addr[rd_ptr];
  assign MEM_WDATA = entry_data[rd_ptr];
  assign MEM_WREQ  = (state == SB_BUSY);
  assign WRITE_OK  = write_ok_q;
  assign EMPTY     = empty_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table plus multi-cycle sequences.
module tb_store_buffer;

  logic        CLK;
  logic        RST;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_WDATA;
  logic        CPU_WE;
  logic [31:0] CPU_RDATA;
  logic        WRITE_OK;
  logic        EMPTY;
  logic [31:0] MEM_RADDR;
  logic [31:0] MEM_RDATA;
  logic [31:0] MEM_WADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_WREQ;
  logic        MEM_WACK;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_WDATA (CPU_WDATA),
    .CPU_WE    (CPU_WE),
    .CPU_RDATA (CPU_RDATA),
    .WRITE_OK  (WRITE_OK),
    .EMPTY     (EMPTY),
    .MEM_RADDR (MEM_RADDR),
    .MEM_RDATA (MEM_RDATA),
    .MEM_WADDR (MEM_WADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_WREQ  (MEM_WREQ),
    .MEM_WACK  (MEM_WACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] exp;
  } vec_t;

  ent_t sb_q[$];
  vec_t tbl[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected load data: youngest pending entry with this address, else memory.
  function automatic logic [31:0] fwd_exp(input logic [31:0] a, input logic [31:0] md);
    logic [31:0] r;
    r = md;
    foreach (sb_q[i]) if (sb_q[i].addr == a) r = sb_q[i].data;
    return r;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_ok);
    ent_t e;
    CPU_ADDR  = a;
    CPU_WDATA = d;
    MEM_RDATA = ~d;
    MEM_WACK  = 1'b0;
    CPU_WE    = 1'b1;
    tick();
    chk("store_write_ok", 32'(WRITE_OK), 32'(exp_ok));
    if (exp_ok) begin
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
      chk("store_fwd", CPU_RDATA, fwd_exp(a, ~d));
    end
    chk("store_empty", 32'(EMPTY), 32'(sb_q.size() == 0));
    CPU_WE = 1'b0;
    tick();
    chk("store_ok_drop", 32'(WRITE_OK), 32'(0));
  endtask

  // One acknowledged drain beat; compares the head against the scoreboard.
  task automatic ack_cycle();
    ent_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_underflow: got empty model expected pending entry");
      return;
    end
    e         = sb_q[0];
    CPU_WE    = 1'b0;
    CPU_ADDR  = e.addr;
    MEM_RDATA = ~e.data;
    MEM_WACK  = 1'b1;
    #1;
    chk("drain_wreq", 32'(MEM_WREQ), 32'(1));
    chk("drain_waddr", MEM_WADDR, e.addr);
    chk("drain_wdata", MEM_WDATA, e.data);
    chk("head_fwd", CPU_RDATA, fwd_exp(e.addr, ~e.data));
    tick();
    void'(sb_q.pop_front());
    MEM_WACK = 1'b0;
    chk("drain_empty", 32'(EMPTY), 32'(sb_q.size() == 0));
    chk("drain_wreq_after", 32'(MEM_WREQ), 32'(sb_q.size() != 0));
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 16) begin
      ack_cycle();
      guard++;
    end
    chk("drained_wreq", 32'(MEM_WREQ), 32'(0));
    chk("drained_empty", 32'(EMPTY), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ok_cnt;
    ent_t e;

    RST       = 1'b1;
    CPU_ADDR  = '0;
    CPU_WDATA = '0;
    CPU_WE    = 1'b0;
    MEM_RDATA = '0;
    MEM_WACK  = 1'b0;

    // Reset state.
    repeat (2) tick();
    RST = 1'b0;
    chk("rst_write_ok", 32'(WRITE_OK), 32'(0));
    chk("rst_wreq", 32'(MEM_WREQ), 32'(0));
    chk("rst_empty", 32'(EMPTY), 32'(1));

    // Single store with CPU_WE held for three cycles.
    CPU_ADDR  = 32'h100;
    CPU_WDATA = 32'hDEADBEEF;
    MEM_RDATA = 32'h0;
    CPU_WE    = 1'b1;
    ok_cnt    = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      ok_cnt += int'(WRITE_OK);
      if (c == 0) begin
        chk("single_ok", 32'(WRITE_OK), 32'(1));
        chk("single_wreq", 32'(MEM_WREQ), 32'(1));
        chk("single_waddr", MEM_WADDR, 32'h100);
        chk("single_wdata", MEM_WDATA, 32'hDEADBEEF);
        chk("single_empty", 32'(EMPTY), 32'(0));
        chk("single_fwd", CPU_RDATA, 32'hDEADBEEF);
        chk("single_raddr", MEM_RADDR, 32'h100);
      end
    end
    chk("single_ok_pulses", 32'(ok_cnt), 32'(1));
    e.addr = 32'h100;
    e.data = 32'hDEADBEEF;
    sb_q.push_back(e);
    CPU_WE = 1'b0;
    tick();
    drain_all();

    // Vector table: forwarding and filling the buffer.
    tbl[0] = '{1'b0, 32'h200, 32'h11, 32'h0, 32'h1};
    tbl[1] = '{1'b0, 32'h200, 32'h22, 32'h0, 32'h1};
    tbl[2] = '{1'b1, 32'h200, 32'h0, 32'h0, 32'h22};
    tbl[3] = '{1'b1, 32'h204, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 32'h300, 32'h33, 32'h0, 32'h1};
    tbl[5] = '{1'b0, 32'h400, 32'h44, 32'h0, 32'h1};
    tbl[6] = '{1'b0, 32'h500, 32'h55, 32'h0, 32'h0};
    tbl[7] = '{1'b1, 32'h300, 32'h0, 32'h0, 32'h33};
    tbl[8] = '{1'b1, 32'h500, 32'h0, 32'h12345678, 32'h12345678};
    foreach (tbl[i]) begin
      if (tbl[i].is_load) begin
        CPU_WE    = 1'b0;
        CPU_ADDR  = tbl[i].addr;
        MEM_RDATA = tbl[i].mem_rdata;
        #1;
        chk("load_rdata", CPU_RDATA, tbl[i].exp);
        chk("load_raddr", MEM_RADDR, tbl[i].addr);
        tick();
      end else begin
        store(tbl[i].addr, tbl[i].wdata, tbl[i].exp[0]);
      end
    end

    // Full buffer: held store waits for a pop, then is taken one edge later.
    CPU_ADDR  = 32'h500;
    CPU_WDATA = 32'h55;
    CPU_WE    = 1'b1;
    tick();
    chk("full_no_ok", 32'(WRITE_OK), 32'(0));
    chk("full_wreq", 32'(MEM_WREQ), 32'(1));
    e = sb_q[0];
    MEM_WACK = 1'b1;
    #1;
    chk("full_head_addr", MEM_WADDR, e.addr);
    chk("full_head_data", MEM_WDATA, e.data);
    tick();
    void'(sb_q.pop_front());
    MEM_WACK = 1'b0;
    chk("full_pop_no_push", 32'(WRITE_OK), 32'(0));
    tick();
    chk("full_late_ok", 32'(WRITE_OK), 32'(1));
    e.addr = 32'h500;
    e.data = 32'h55;
    sb_q.push_back(e);
    CPU_WE = 1'b0;
    tick();
    chk("full_late_drop", 32'(WRITE_OK), 32'(0));

    // Back-to-back drain of all four entries.
    drain_all();

    // Simultaneous push and pop with two entries pending.
    store(32'h600, 32'h66, 1'b1);
    store(32'h700, 32'h77, 1'b1);
    e         = sb_q[0];
    CPU_ADDR  = 32'h800;
    CPU_WDATA = 32'h88;
    CPU_WE    = 1'b1;
    MEM_WACK  = 1'b1;
    #1;
    chk("pp_head_before", MEM_WADDR, e.addr);
    tick();
    void'(sb_q.pop_front());
    e.addr = 32'h800;
    e.data = 32'h88;
    sb_q.push_back(e);
    chk("pp_write_ok", 32'(WRITE_OK), 32'(1));
    chk("pp_head_after", MEM_WADDR, sb_q[0].addr);
    chk("pp_empty", 32'(EMPTY), 32'(0));
    CPU_WE   = 1'b0;
    MEM_WACK = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      store(32'h900 + 32'(i * 16), 32'h9000 + 32'(i), 1'b1);
      ack_cycle();
    end
    drain_all();

    // Reset while draining discards everything.
    store(32'hA00, 32'hAA, 1'b1);
    store(32'hB00, 32'hBB, 1'b1);
    store(32'hC00, 32'hCC, 1'b1);
    chk("mid_wreq", 32'(MEM_WREQ), 32'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb_q.delete();
    chk("mid_rst_wreq", 32'(MEM_WREQ), 32'(0));
    chk("mid_rst_empty", 32'(EMPTY), 32'(1));
    chk("mid_rst_ok", 32'(WRITE_OK), 32'(0));
    CPU_ADDR  = 32'hA00;
    MEM_RDATA = 32'h5555AAAA;
    #1;
    chk("mid_rst_load", CPU_RDATA, 32'h5555AAAA);
    tick();
    chk("mid_rst_wreq_hold", 32'(MEM_WREQ), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
